axis_test_ram_writer: RTL and testbench
=======================================

# axis_test_ram_writer

Test-infrastructure AXI-stream sink; the receiving counterpart of the ROM-backed stream source used in golden benches. It captures one frame of a DUT output stream into an internal RAM of DEPTH words and checks the frame length against `ds_last`. It drives `ds_ready` with a configurable backpressure pattern, reports a 3-bit verdict, and exposes a synchronous read port so the bench can dump or compare the captured words after the frame completes.

## Interface
Parameters:
- WIDTH, 32, data word width
- DEPTH, 64, expected frame length in words (≥2); RAM size
- READY_PATTERN, 16'hFFFF, rotating `ds_ready` enable mask; bit 0 is used first

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; arms capture of one frame
- ds_data  in  WIDTH  stream data
- ds_valid  in  1  stream valid
- ds_last  in  1  marks final word of the frame
- ds_ready  out  1  sink ready
- busy  out  1  high in CAPTURE
- done  out  1  high in DONE or ERROR; sticky until next `start`
- result  out  3  verdict, encoding below
- count  out  $clog2(DEPTH+1)  words accepted in current or last frame
- rd_addr  in  $clog2(DEPTH)  readback address
- rd_data  out  WIDTH  RAM word at `rd_addr`, one cycle after the address is applied

## Operation
- Beat = `ds_valid && ds_ready` on a rising edge. Only beats write the RAM (address = `count`) and increment `count`.
- FSM states: IDLE, CAPTURE, DONE, ERROR.
  - IDLE: `ds_ready`=0. `start` → CAPTURE; `count` cleared; pattern pointer reset to bit 0.
  - CAPTURE: `ds_ready` = READY_PATTERN[ptr]. `ptr` advances modulo 16 every cycle in CAPTURE, beat or not.
    - Beat with `ds_last`=1 and `count`==DEPTH-1 → DONE, result PASS.
    - Beat with `ds_last`=1 and `count`<DEPTH-1 → ERROR, result SHORT.
    - Beat with `ds_last`=0 and `count`==DEPTH-1 → ERROR, result LONG. The word is stored and no further beats are accepted.
  - DONE / ERROR: `ds_ready`=0. `start` → CAPTURE (re-arm, `result` back to RUNNING).
- `start` while in CAPTURE is ignored.
- Result encoding, shared enum: 0 IDLE, 1 RUNNING, 2 PASS, 3 SHORT, 4 LONG. Values 5–7 are never driven.
- Readback: `rd_data` is valid for any address in every state. Words at or above `count` hold stale contents.
- An all-zero READY_PATTERN is illegal and is rejected by an elaboration-time assertion.

## Timing
- Reset (async assert, sync deassert handled externally): state IDLE, `ds_ready`=0, `busy`=0, `done`=0, `result`=IDLE, `count`=0, `ptr`=0, `rd_data`=0. RAM contents are undefined.
- `ds_ready` is a registered output; it never depends combinationally on `ds_valid`.
- `start` at edge N → `ds_ready`=READY_PATTERN[0] and `busy`=1 from N+1.
- Terminating beat at edge N: state/`result`/`done`/`count` updated at N+1, and `ds_ready` is 0 from N+1. Because `ds_ready` is registered, it must be computed from next-state, so no extra beat is accepted at N+1.
- With READY_PATTERN all-ones and `ds_valid` held high, throughput is 1 word/cycle and a frame takes DEPTH cycles.
- Reset mid-frame: immediate return to IDLE; partial capture is discarded (`count`=0).

## Structure
- Package `axis_test_pkg`: `axis_test_result_t` enum (IDLE…LONG, 3 bits) and `capture_state_t`. The comparator-side code is to use the same result enum.
- Sub-module `simple_dual_port_ram` (WIDTH, DEPTH): one write port, one registered read port. It is inferable as BRAM/LUTRAM and holds no reset on its storage.
- Top-level contents: FSM, `count`, `ptr`, and registered `ds_ready`.

## Test plan
- DEPTH=8, all-ones pattern; source sends 8 words 0x10…0x17 with `ds_last` on the 8th → `result`=PASS after 8 beats, `count`=8, readback addr 3 = 0x13.
- DEPTH=8; `ds_last` on word 5 → `result`=SHORT, `count`=5, `ds_ready`=0 thereafter, and word 6 is never accepted.
- DEPTH=8; no `ds_last` on word 8 → `result`=LONG, `count`=8, and the source's 9th word stalls indefinitely.
- READY_PATTERN=16'h5555, `ds_valid` constant → beats only on alternate cycles, frame takes 15 cycles for DEPTH=8, and data is stored in order.
- Assert `rst` low after 4 beats → all outputs return to reset values at once. Then `start` plus a full frame → PASS.
- Two back-to-back frames via `start` in DONE → second `result`=PASS, and readback shows the second frame's data.

Source files
------------

// File: rtl/axis_test_pkg.sv
// axis_test_pkg: result verdict and capture FSM types shared by stream sink and comparator code
package axis_test_pkg;
   typedef enum logic [2:0] {
      RES_IDLE    = 3'd0,
      RES_RUNNING = 3'd1,
      RES_PASS    = 3'd2,
      RES_SHORT   = 3'd3,
      RES_LONG    = 3'd4
   } axis_test_result_t;
   typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DONE, ST_ERROR} capture_state_t;
endpackage

// File: rtl/simple_dual_port_ram.sv
// simple_dual_port_ram: one write port, one registered read port, unreset storage
module simple_dual_port_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[wr_addr] <= wr_data;
   // only the read register is reset so the array still maps onto block/LUT RAM
   always_ff @(posedge clk or negedge rst)
      if (!rst) rd_data <= '0;
      else rd_data <= mem[rd_addr];
endmodule

// File: rtl/axis_test_ram_writer.sv
// axis_test_ram_writer: captures one AXI-stream frame into RAM with patterned backpressure
// and a length verdict against ds_last
module axis_test_ram_writer
   import axis_test_pkg::*;
#(
   parameter int          WIDTH         = 32,
   parameter int          DEPTH         = 64,
   parameter logic [15:0] READY_PATTERN = 16'hFFFF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [WIDTH-1:0]           ds_data,
   input  logic                       ds_valid,
   input  logic                       ds_last,
   output logic                       ds_ready,
   output logic                       busy,
   output logic                       done,
   output logic [2:0]                 result,
   output logic [$clog2(DEPTH+1)-1:0] count,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic [WIDTH-1:0]           rd_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   if (READY_PATTERN == 16'h0) begin : g_bad_pattern
      $error("READY_PATTERN must have at least one bit set");
   end

   capture_state_t    state;
   axis_test_result_t res;
   logic [3:0]        ptr;
   logic              beat, at_end;

   assign beat   = ds_valid && ds_ready;
   assign at_end = count == CW'(DEPTH-1);
   assign result = res;

   // ds_ready is registered, so a terminating beat must clear it in the same edge
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state    <= ST_IDLE;
         res      <= RES_IDLE;
         ds_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         count    <= '0;
         ptr      <= '0;
      end else if (state == ST_CAPTURE) begin
         ptr      <= ptr + 4'd1;
         ds_ready <= READY_PATTERN[ptr + 4'd1];
         if (beat) begin
            count <= count + 1'b1;
            if (ds_last || at_end) begin
               state    <= ds_last && at_end ? ST_DONE : ST_ERROR;
               res      <= !ds_last ? RES_LONG : at_end ? RES_PASS : RES_SHORT;
               ds_ready <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b1;
            end
         end
      end else if (start) begin
         state    <= ST_CAPTURE;
         res      <= RES_RUNNING;
         ds_ready <= READY_PATTERN[0];
         busy     <= 1'b1;
         done     <= 1'b0;
         count    <= '0;
         ptr      <= '0;
      end

   simple_dual_port_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (beat),
      .wr_addr (count[AW-1:0]),
      .wr_data (ds_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );
endmodule

// File: tb/tb_axis_test_ram_writer.sv
// tb_axis_test_ram_writer: scoreboard bench, all-ones and 5555 backpressure instances, DEPTH=8
module tb_axis_test_ram_writer;
   logic        clk = 0, rst = 0;
   logic        start_a = 0, valid_a = 0, last_a = 0, ready_a, busy_a, done_a;
   logic [31:0] data_a = 0, rd_data_a;
   logic [2:0]  result_a, rd_addr_a = 0;
   logic [3:0]  count_a;
   logic        start_b = 0, valid_b = 0, last_b = 0, ready_b, busy_b, done_b;
   logic [31:0] data_b = 0, rd_data_b;
   logic [2:0]  result_b, rd_addr_b = 0;
   logic [3:0]  count_b;
   logic [31:0] exp_q[$];
   int          passed = 0, total = 0;
   int          acc, cyc;

   always #5 clk = ~clk;

   axis_test_ram_writer #(.WIDTH(32), .DEPTH(8), .READY_PATTERN(16'hFFFF)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .ds_data(data_a), .ds_valid(valid_a),
      .ds_last(last_a), .ds_ready(ready_a), .busy(busy_a), .done(done_a),
      .result(result_a), .count(count_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a));

   axis_test_ram_writer #(.WIDTH(32), .DEPTH(8), .READY_PATTERN(16'h5555)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .ds_data(data_b), .ds_valid(valid_b),
      .ds_last(last_b), .ds_ready(ready_b), .busy(busy_b), .done(done_b),
      .result(result_b), .count(count_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   task automatic pulse_a();
      @(posedge clk); #1 start_a = 1;
      @(posedge clk); #1 start_a = 0;
   endtask

   // drives n words; pushes each accepted word; stops after n accepts or a stall budget
   task automatic send_a(input logic [31:0] base, input int n, input int last_idx,
                         output int a, output int c);
      a = 0; c = 0;
      valid_a = 1; data_a = base; last_a = (last_idx == 0);
      while (a < n && c < n + 12) begin
         @(negedge clk); c++;
         if (ready_a) begin exp_q.push_back(data_a); a++; end
         @(posedge clk); #1;
         data_a = base + 32'(a); last_a = (a == last_idx);
      end
      valid_a = 0; last_a = 0;
   endtask

   task automatic readback(input bit sel_b);
      int i = 0;
      while (exp_q.size() > 0) begin
         rd_addr_a = 3'(i); rd_addr_b = 3'(i);
         @(posedge clk); @(negedge clk);
         check(sel_b ? "rd_b" : "rd_a", sel_b ? rd_data_b : rd_data_a, exp_q.pop_front());
         i++;
      end
   endtask

   task automatic status_a(input string tag, input logic [2:0] res, input logic [3:0] cnt);
      check({tag, "_result"}, 32'(result_a), 32'(res));
      check({tag, "_count"}, 32'(count_a), 32'(cnt));
      check({tag, "_done"}, 32'(done_a), 1);
      check({tag, "_busy"}, 32'(busy_a), 0);
      check({tag, "_ready"}, 32'(ready_a), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      #12;
      check("rst_ready", 32'(ready_a), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_result", 32'(result_a), 0);
      check("rst_count", 32'(count_a), 0);
      check("rst_rd", rd_data_a, 0);
      check("rst_rd_b", rd_data_b, 0);
      @(posedge clk); #1 rst = 1;
      repeat (2) @(posedge clk);
      check("idle_ready", 32'(ready_a), 0);

      // full frame, all-ones pattern
      pulse_a();
      check("start_ready", 32'(ready_a), 1);
      check("start_busy", 32'(busy_a), 1);
      check("start_result", 32'(result_a), 1);
      send_a(32'h10, 8, 7, acc, cyc);
      check("pass_acc", 32'(acc), 8);
      check("pass_cycles", 32'(cyc), 8);
      status_a("pass", 3'd2, 4'd8);
      rd_addr_a = 3; @(posedge clk); @(negedge clk);
      check("rd_addr3", rd_data_a, 32'h13);
      readback(0);

      // short frame: last on 5th word, 6th never accepted
      pulse_a();
      send_a(32'h20, 6, 4, acc, cyc);
      check("short_acc", 32'(acc), 5);
      status_a("short", 3'd3, 4'd5);
      readback(0);

      // long frame: no last on 8th word, 9th stalls
      pulse_a();
      send_a(32'h30, 9, -1, acc, cyc);
      check("long_acc", 32'(acc), 8);
      status_a("long", 3'd4, 4'd8);
      readback(0);

      // reset after 4 beats
      pulse_a();
      send_a(32'h40, 4, -1, acc, cyc);
      check("mid_acc", 32'(acc), 4);
      check("mid_busy", 32'(busy_a), 1);
      rst = 0; #2;
      check("mrst_ready", 32'(ready_a), 0);
      check("mrst_busy", 32'(busy_a), 0);
      check("mrst_done", 32'(done_a), 0);
      check("mrst_result", 32'(result_a), 0);
      check("mrst_count", 32'(count_a), 0);
      check("mrst_rd", rd_data_a, 0);
      exp_q.delete();
      @(posedge clk); #1 rst = 1;
      pulse_a();
      send_a(32'h48, 8, 7, acc, cyc);
      status_a("post_rst", 3'd2, 4'd8);
      readback(0);

      // back-to-back frame re-armed from DONE
      pulse_a();
      check("rearm_result", 32'(result_a), 1);
      check("rearm_done", 32'(done_a), 0);
      send_a(32'h50, 8, 7, acc, cyc);
      status_a("b2b", 3'd2, 4'd8);
      readback(0);

      // alternate-cycle backpressure, valid held high
      @(posedge clk); #1 start_b = 1;
      @(posedge clk); #1 start_b = 0;
      valid_b = 1; data_b = 32'h60; last_b = 0;
      acc = 0; cyc = 0;
      while (!done_b && cyc < 40) begin
         @(negedge clk);
         if (busy_b) cyc++;
         if (ready_b) begin exp_q.push_back(data_b); acc++; end
         @(posedge clk); #1;
         data_b = 32'h60 + 32'(acc); last_b = (acc == 7);
      end
      valid_b = 0; last_b = 0;
      check("alt_cycles", 32'(cyc), 15);
      check("alt_acc", 32'(acc), 8);
      check("alt_result", 32'(result_b), 2);
      check("alt_count", 32'(count_b), 8);
      readback(1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
